// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the 5-stage core pipeline registers.
//   NOP_INSTR      : instruction encoding used as the bubble payload
//   CNT_W_DEFAULT  : default width of the per-stage squash counters
//   *_t            : packed payload layouts carried between stages
// ---------------------------------------------------------------------------
package pipe_pkg;

   localparam logic [31:0] NOP_INSTR     = 32'b0;
   localparam int          CNT_W_DEFAULT = 16;

   // Fetch -> decode: program counter plus raw instruction word.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } if_id_t;

   // Decode -> execute: operands and the control bits the ALU stage needs.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] rs1Val;
      logic [31:0] rs2Val;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic [3:0]  aluOp;
      logic        regWrite;
      logic        memRead;
      logic        memWrite;
   } id_ex_t;

   // Execute -> memory: ALU result and store data.
   typedef struct packed {
      logic [31:0] aluResult;
      logic [31:0] storeData;
      logic [4:0]  rd;
      logic        regWrite;
      logic        memRead;
      logic        memWrite;
   } ex_mem_t;

   // Memory -> writeback: value to retire into the register file.
   typedef struct packed {
      logic [31:0] wbData;
      logic [4:0]  rd;
      logic        regWrite;
   } mem_wb_t;

endpackage

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
// Generic valid/ready pipeline register between two core stages, with an
// optional one-entry skid buffer, hazard freeze, branch flush and a
// saturating count of squashed entries.
//
// Parameters
//   DATA_W    : payload width
//   RESET_VAL : payload after reset and after flush (bubble encoding)
//   SKID      : 1 = main + skid entry with registered in_ready
//               0 = single entry, in_ready depends combinationally on out_ready
//   CNT_W     : squash counter width
//
// Ports
//   clk, rst    : rising-edge clock, asynchronous active-high reset
//   flush       : squash every held entry this cycle (highest priority)
//   freeze      : hold all state, block both handshakes
//   in_valid    : upstream offers in_data
//   in_ready    : stage accepts in_data this cycle
//   in_data     : upstream payload
//   out_valid   : main entry offered downstream
//   out_ready   : downstream accepts
//   out_data    : main entry payload (visible even while frozen)
//   occupancy   : number of valid entries held (0..2)
//   squash_cnt  : saturating count of valid entries killed by flush
// ---------------------------------------------------------------------------
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int                DATA_W    = 64,
   parameter logic [DATA_W-1:0] RESET_VAL = DATA_W'(NOP_INSTR),
   parameter bit                SKID      = 1'b1,
   parameter int                CNT_W     = CNT_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              freeze,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  squash_cnt
);

   logic              r_mainValid;
   logic [DATA_W-1:0] r_mainData;
   logic              w_skidValid;
   logic              w_inFire;
   logic              w_outFire;
   logic [1:0]        w_occupancy;
   logic [CNT_W:0]    w_squashSum;
   logic [CNT_W-1:0]  r_squashCnt;

   // The output handshake is also closed during flush so that nothing can
   // leave the stage in the same cycle it is being squashed.
   assign out_valid   = r_mainValid & ~freeze & ~flush;
   assign out_data    = r_mainData;
   assign w_inFire    = in_valid & in_ready;
   assign w_outFire   = out_valid & out_ready;
   assign w_occupancy = {1'b0, r_mainValid} + {1'b0, w_skidValid};
   assign occupancy   = w_occupancy;

   generate
      if (SKID) begin : g_skid
         logic              r_skidValid;
         logic [DATA_W-1:0] r_skidData;

         assign w_skidValid = r_skidValid;

         // Ready only looks at our own registers, which breaks the
         // combinational ready chain running back up the pipeline.
         assign in_ready = ~r_skidValid & ~freeze & ~flush;

         // Main entry refills from the skid first so older payloads always
         // leave before newer ones; the skid only catches a payload that
         // arrives while main is full and not draining.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_mainValid <= 1'b0;
               r_mainData  <= RESET_VAL;
               r_skidValid <= 1'b0;
               r_skidData  <= RESET_VAL;
            end else if (flush) begin
               r_mainValid <= 1'b0;
               r_mainData  <= RESET_VAL;
               r_skidValid <= 1'b0;
               r_skidData  <= RESET_VAL;
            end else if (!freeze) begin
               if (!r_mainValid || w_outFire) begin
                  if (r_skidValid) begin
                     r_mainValid <= 1'b1;
                     r_mainData  <= r_skidData;
                     r_skidValid <= 1'b0;
                  end else if (w_inFire) begin
                     r_mainValid <= 1'b1;
                     r_mainData  <= in_data;
                  end else begin
                     r_mainValid <= 1'b0;
                  end
               end else if (w_inFire) begin
                  r_skidValid <= 1'b1;
                  r_skidData  <= in_data;
               end
            end
         end
      end else begin : g_noSkid
         assign w_skidValid = 1'b0;

         // Single entry: we may accept while full only if the current
         // occupant leaves in the same cycle.
         assign in_ready = (~r_mainValid | out_ready) & ~freeze & ~flush;

         // Load on accept, empty on a drain with nothing arriving behind it.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_mainValid <= 1'b0;
               r_mainData  <= RESET_VAL;
            end else if (flush) begin
               r_mainValid <= 1'b0;
               r_mainData  <= RESET_VAL;
            end else if (!freeze) begin
               if (w_inFire) begin
                  r_mainValid <= 1'b1;
                  r_mainData  <= in_data;
               end else if (w_outFire) begin
                  r_mainValid <= 1'b0;
               end
            end
         end
      end
   endgenerate

   // Sum is one bit wider than the counter so a carry out marks overflow.
   assign w_squashSum = {1'b0, r_squashCnt} + (CNT_W+1)'(w_occupancy);

   // Squash counter: adds every valid entry killed by a flush and sticks at
   // all-ones instead of wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_squashCnt <= '0;
      end else if (flush) begin
         r_squashCnt <= w_squashSum[CNT_W] ? '1 : w_squashSum[CNT_W-1:0];
      end
   end

   assign squash_cnt = r_squashCnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
// Drives two stage registers: dutA (SKID=1, 16-bit counter) and dutB
// (SKID=0, 2-bit counter). Each is compared every cycle against a queue
// model of the entries the stage should hold.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   logic        aFlush, aFreeze, aInValid, aInReady, aOutValid, aOutReady;
   logic [63:0] aInData, aOutData;
   logic [1:0]  aOcc;
   logic [15:0] aCnt;

   logic        bFlush, bFreeze, bInValid, bInReady, bOutValid, bOutReady;
   logic [63:0] bInData, bOutData;
   logic [1:0]  bOcc;
   logic [1:0]  bCnt;

   pipe_stage_reg #(.DATA_W(64), .SKID(1'b1), .CNT_W(16)) dutA (
      .clk(clk), .rst(rst), .flush(aFlush), .freeze(aFreeze),
      .in_valid(aInValid), .in_ready(aInReady), .in_data(aInData),
      .out_valid(aOutValid), .out_ready(aOutReady), .out_data(aOutData),
      .occupancy(aOcc), .squash_cnt(aCnt)
   );

   pipe_stage_reg #(.DATA_W(64), .SKID(1'b0), .CNT_W(2)) dutB (
      .clk(clk), .rst(rst), .flush(bFlush), .freeze(bFreeze),
      .in_valid(bInValid), .in_ready(bInReady), .in_data(bInData),
      .out_valid(bOutValid), .out_ready(bOutReady), .out_data(bOutData),
      .occupancy(bOcc), .squash_cnt(bCnt)
   );

   int testsRun    = 0;
   int testsFailed = 0;

   // Reference state: payloads in arrival order, squash count, and the
   // payload the main register still shows once the stage has drained.
   logic [63:0] qA[$];
   logic [63:0] qB[$];
   int          cntA, cntB;
   logic [63:0] lastA, lastB;

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // One clock cycle on the selected DUT (sel=0 -> A, sel=1 -> B); the
   // other DUT is held idle. Outputs are sampled mid-cycle, then the model
   // is advanced by the handshakes the rules say must happen.
   task automatic applyStimulus(input bit sel, input bit inV, input logic [63:0] d,
                                input bit outR, input bit frz, input bit fl,
                                output bit inFired);
      logic [63:0] q[$];
      logic [63:0] last, obsData, expData;
      int          cnt, cntMax, sz;
      bit          expReady, expValid, outFire;
      logic        obsReady, obsValid;
      logic [1:0]  obsOcc;
      logic [63:0] obsCnt;
      string       pfx;

      if (!sel) begin
         aInValid = inV; aInData = d; aOutReady = outR; aFreeze = frz; aFlush = fl;
         bInValid = 1'b0; bOutReady = 1'b0; bFreeze = 1'b0; bFlush = 1'b0;
         q = qA; cnt = cntA; last = lastA; cntMax = 65535; pfx = "A";
      end else begin
         bInValid = inV; bInData = d; bOutReady = outR; bFreeze = frz; bFlush = fl;
         aInValid = 1'b0; aOutReady = 1'b0; aFreeze = 1'b0; aFlush = 1'b0;
         q = qB; cnt = cntB; last = lastB; cntMax = 3; pfx = "B";
      end

      #4;
      sz       = q.size();
      expReady = !fl && !frz && (sel ? (sz == 0 || outR) : (sz < 2));
      expValid = (sz > 0) && !frz && !fl;
      expData  = (sz > 0) ? q[0] : last;

      if (!sel) begin
         obsReady = aInReady; obsValid = aOutValid; obsData = aOutData;
         obsOcc = aOcc; obsCnt = 64'(aCnt);
      end else begin
         obsReady = bInReady; obsValid = bOutValid; obsData = bOutData;
         obsOcc = bOcc; obsCnt = 64'(bCnt);
      end

      checkOutput({pfx, " in_ready"},   64'(obsReady), 64'(expReady));
      checkOutput({pfx, " out_valid"},  64'(obsValid), 64'(expValid));
      checkOutput({pfx, " out_data"},   obsData, expData);
      checkOutput({pfx, " occupancy"},  64'(obsOcc), 64'(sz));
      checkOutput({pfx, " squash_cnt"}, obsCnt, 64'(cnt));

      inFired = 1'b0;
      if (fl) begin
         cnt  = (cnt + sz > cntMax) ? cntMax : cnt + sz;
         q.delete();
         last = 64'h0;
      end else if (!frz) begin
         outFire = expValid && outR;
         inFired = inV && expReady;
         if (outFire) last = q.pop_front();
         if (inFired) q.push_back(d);
      end

      if (!sel) begin qA = q; cntA = cnt; lastA = last; end
      else      begin qB = q; cntB = cnt; lastB = last; end

      @(posedge clk);
      #1;
   endtask

   task automatic clearModels();
      qA.delete(); qB.delete();
      cntA = 0; cntB = 0; lastA = 64'h0; lastB = 64'h0;
   endtask

   // Random traffic on one DUT; a payload once offered is held until it is
   // accepted, or dropped only by a flush.
   task automatic randomTraffic(input bit sel, input int cycles);
      bit          pendV, fired, fl, frz, outR;
      logic [63:0] pendD;
      pendV = 1'b0;
      pendD = 64'h0;
      for (int i = 0; i < cycles; i++) begin
         if (!pendV && ($urandom_range(0, 3) != 0)) begin
            pendV = 1'b1;
            pendD = {$urandom, $urandom};
         end
         fl   = ($urandom_range(0, 19) == 0);
         frz  = ($urandom_range(0, 7) == 0);
         outR = ($urandom_range(0, 2) != 0);
         applyStimulus(sel, pendV, pendD, outR, frz, fl, fired);
         if (fired || fl) pendV = 1'b0;
      end
   endtask

   initial begin
      bit f;

      aFlush = 0; aFreeze = 0; aInValid = 0; aInData = 0; aOutReady = 0;
      bFlush = 0; bFreeze = 0; bInValid = 0; bInData = 0; bOutReady = 0;
      rst = 1'b1;
      clearModels();
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      @(posedge clk);
      #1;

      // Post-reset state of both variants.
      applyStimulus(0, 0, 64'h0, 0, 0, 0, f);
      applyStimulus(1, 0, 64'h0, 0, 0, 0, f);

      // Back-to-back streaming through the skid variant.
      for (int i = 1; i <= 4; i++) applyStimulus(0, 1, 64'(i), 1, 0, 0, f);
      applyStimulus(0, 0, 64'h0, 1, 0, 0, f);
      applyStimulus(0, 0, 64'h0, 1, 0, 0, f);

      // Backpressure fills the skid; 0xC must wait until it empties.
      applyStimulus(0, 1, 64'hA, 0, 0, 0, f);
      applyStimulus(0, 1, 64'hB, 0, 0, 0, f);
      applyStimulus(0, 1, 64'hC, 0, 0, 0, f);
      applyStimulus(0, 1, 64'hC, 1, 0, 0, f);
      applyStimulus(0, 1, 64'hC, 1, 0, 0, f);
      applyStimulus(0, 0, 64'h0, 1, 0, 0, f);
      applyStimulus(0, 0, 64'h0, 1, 0, 0, f);

      // Freeze for three cycles with an entry held and input offered.
      applyStimulus(0, 1, 64'h11, 0, 0, 0, f);
      repeat (3) applyStimulus(0, 1, 64'h22, 1, 1, 0, f);
      applyStimulus(0, 0, 64'h0, 1, 0, 0, f);
      applyStimulus(0, 0, 64'h0, 1, 0, 0, f);

      // Flush with both entries full and an input on offer.
      applyStimulus(0, 1, 64'h31, 0, 0, 0, f);
      applyStimulus(0, 1, 64'h32, 0, 0, 0, f);
      applyStimulus(0, 1, 64'h33, 1, 0, 1, f);
      applyStimulus(0, 0, 64'h0, 1, 0, 0, f);
      applyStimulus(0, 0, 64'h0, 1, 0, 0, f);

      // Counter saturation on the 2-bit single-entry variant.
      for (int k = 0; k < 5; k++) begin
         applyStimulus(1, 1, 64'(k + 16), 0, 0, 0, f);
         applyStimulus(1, 1, 64'(k + 116), 0, 0, 0, f);
         applyStimulus(1, 1, 64'h77, 0, 0, 1, f);
      end
      applyStimulus(1, 1, 64'h5, 0, 0, 0, f);
      applyStimulus(1, 1, 64'h6, 1, 0, 0, f);
      applyStimulus(1, 0, 64'h0, 1, 0, 0, f);
      applyStimulus(1, 0, 64'h0, 1, 0, 0, f);

      // Asynchronous reset in the middle of a cycle with the skid full.
      applyStimulus(0, 1, 64'hA1, 0, 0, 0, f);
      applyStimulus(0, 1, 64'hA2, 0, 0, 0, f);
      aInValid = 1'b0;
      #3 rst = 1'b1;
      #1;
      checkOutput("A rst out_valid",  64'(aOutValid), 64'h0);
      checkOutput("A rst out_data",   aOutData, 64'h0);
      checkOutput("A rst occupancy",  64'(aOcc), 64'h0);
      checkOutput("A rst squash_cnt", 64'(aCnt), 64'h0);
      checkOutput("B rst squash_cnt", 64'(bCnt), 64'h0);
      #2 rst = 1'b0;
      clearModels();
      @(posedge clk);
      #1;
      applyStimulus(0, 0, 64'h0, 1, 0, 0, f);

      // Random traffic on both variants.
      randomTraffic(0, 400);
      randomTraffic(1, 300);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
